// File: rtl/seq_gen_pkg.sv
// Shared types and width helpers for the serial pattern transmitter.
// The state encoding is fixed so that waveforms read the same across every block that uses it.
package seq_gen_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Bits needed for a counter that runs 0..n-1, never narrower than one bit.
    function automatic int cnt_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_gen_moore_if.sv
// Request/serial-output bundle of seq_gen_moore.
// The master side issues requests; the slave side is the transmitter itself.
interface seq_gen_moore_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) ();

    logic             start;
    logic [WIDTH-1:0] pattern;
    logic [CNT_W-1:0] repeat_cnt;
    logic             dout;
    logic             dout_valid;
    logic             busy;
    logic             done;

    modport master (
        output start, pattern, repeat_cnt,
        input  dout, dout_valid, busy, done
    );

    modport slave (
        input  start, pattern, repeat_cnt,
        output dout, dout_valid, busy, done
    );

endinterface

// File: rtl/piso_shreg.sv
// Parallel-in/serial-out shift register, MSB first, zero fill.
// A load on the same edge as a shift request wins, which makes back-to-back frame reloads seamless.
module piso_shreg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);

    logic [WIDTH-1:0] q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift_en) begin
            q <= {q[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = q[WIDTH-1];

endmodule

// File: rtl/seq_gen_moore.sv
// Serial pattern transmitter: sends a latched WIDTH-bit pattern MSB-first, repeat_cnt times,
// with GAP idle cycles between frames, then pulses done. Moore FSM, registered outputs.
module seq_gen_moore
    import seq_gen_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4,
    parameter int GAP   = 1
) (
    input  logic            clk,
    input  logic            reset,
    seq_gen_moore_if.slave  bus
);

    localparam int BW = cnt_bits(WIDTH);
    localparam int GW = cnt_bits(GAP);

    localparam logic [BW-1:0]    BIT_LAST = BW'(WIDTH - 1);
    localparam logic [GW-1:0]    GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [CNT_W-1:0] ONE_LEFT = CNT_W'(1);

    state_t           state;
    logic [BW-1:0]    bit_cnt;
    logic [GW-1:0]    gap_cnt;
    logic [CNT_W-1:0] frames_left;
    logic [WIDTH-1:0] pat_q;
    logic             valid_q;
    logic             busy_q;
    logic             done_q;

    logic             accept;
    logic             reload;
    logic             load;
    logic             shift_en;
    logic [WIDTH-1:0] load_val;
    logic             shreg_msb;

    // Shift-register control: a fresh start loads the live input, later frames reload the copy.
    always_comb begin
        accept   = (state == S_IDLE) && bus.start;
        reload   = (state == S_SHIFT) && (bit_cnt == BIT_LAST) && (frames_left != ONE_LEFT);
        load     = accept || reload;
        shift_en = (state == S_SHIFT);
        load_val = accept ? bus.pattern : pat_q;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            pat_q <= bus.pattern;
        end
    end

    piso_shreg #(
        .WIDTH (WIDTH)
    ) u_shreg (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .shift_en (shift_en),
        .din      (load_val),
        .msb      (shreg_msb)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            bit_cnt     <= '0;
            gap_cnt     <= '0;
            frames_left <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        frames_left <= bus.repeat_cnt;
                        bit_cnt     <= '0;
                        gap_cnt     <= '0;
                        if (bus.repeat_cnt != '0) begin
                            state   <= S_SHIFT;
                            valid_q <= 1'b1;
                            busy_q  <= 1'b1;
                        end else begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end
                    end
                end

                S_SHIFT: begin
                    if (bit_cnt == BIT_LAST) begin
                        frames_left <= frames_left - ONE_LEFT;
                        bit_cnt     <= '0;
                        if (frames_left == ONE_LEFT) begin
                            state   <= S_DONE;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else if (GAP > 0) begin
                            state   <= S_GAP;
                            gap_cnt <= '0;
                            valid_q <= 1'b0;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + BW'(1);
                    end
                end

                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state   <= S_SHIFT;
                        bit_cnt <= '0;
                        valid_q <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end

                S_DONE: begin
                    state  <= S_IDLE;
                    done_q <= 1'b0;
                end

                default: begin
                    state   <= S_IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // The shift register holds the reloaded pattern during GAP, so dout is gated by valid.
    assign bus.dout       = valid_q & shreg_msb;
    assign bus.dout_valid = valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule
